// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared FSM states, pixel constants and byte-select helper
package edge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PIXELS_PER_WORD = 4;
  localparam int PIXEL_WIDTH     = 8;
  localparam int WORD_WIDTH      = PIXELS_PER_WORD * PIXEL_WIDTH;

  // Byte 0 is the least significant byte and leaves the block first.
  function automatic logic [PIXEL_WIDTH-1:0] pixel_of(
    input logic [WORD_WIDTH-1:0] word,
    input logic [1:0]            idx
  );
    return word[idx*PIXEL_WIDTH +: PIXEL_WIDTH];
  endfunction

endpackage

// File: rtl/word_fifo.sv
// rtl/word_fifo.sv - small synchronous word buffer with occupancy count
module word_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full buffer is accepted when a pop frees a slot in the same cycle.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Pointer and occupancy tracking; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pixel_word_reader.sv
// rtl/pixel_word_reader.sv - reads 32-bit words from memory and streams them as 8-bit pixels
module pixel_word_reader
  import edge_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           num_words,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_dr,
  output logic [7:0]            pix,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_last,
  output logic                  busy,
  output logic                  done
);

  localparam int         CW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [1:0] LAST_BYTE = 2'(PIXELS_PER_WORD - 1);

  state_t        state;
  state_t        state_next;
  logic [15:0]   issue_left;
  logic [15:0]   out_left;
  logic          rd_pend;
  logic [31:0]   word_reg;
  logic [1:0]    byte_idx;
  logic          word_last;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [31:0]   fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          handshake;
  logic          need_word;
  logic          load_word;
  logic          credit_ok;
  logic [31:0]   load_data;

  assign mem_we    = 1'b0;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign pix       = pixel_of(word_reg, byte_idx);
  assign pix_last  = pix_valid && word_last && (byte_idx == LAST_BYTE);
  assign handshake = pix_valid && pix_ready;

  // The serializer takes a new word when idle or as its last byte leaves. When the
  // buffer is empty the word arriving from memory bypasses it, which keeps the
  // start-to-first-pixel latency at three cycles.
  assign need_word = !pix_valid || (handshake && (byte_idx == LAST_BYTE));
  assign load_word = (state == RUN) && need_word && (out_left != 16'd0) &&
                     (!fifo_empty || rd_pend);
  assign load_data = fifo_empty ? mem_dr : fifo_dout;
  assign fifo_pop  = load_word && !fifo_empty;
  assign fifo_push = rd_pend && !(load_word && fifo_empty);

  // Buffered words plus reads in flight must stay below the buffer depth so a
  // returning word always has a slot. A pop in this cycle is not credited.
  assign credit_ok = !fifo_full &&
                     ((32'(fifo_count) + 32'(rd_pend) + 32'(mem_en)) < 32'(FIFO_DEPTH));

  word_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_word_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (mem_dr),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: an empty transfer skips straight to the completion pulse.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (num_words == 16'd0) ? DONE : RUN;
      RUN:     if (handshake && pix_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read issue: the first read goes out right after start, the rest as credit allows.
  // mem_addr only moves with a read, so it holds the last issued address otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en     <= 1'b0;
      mem_addr   <= '0;
      issue_left <= '0;
      rd_pend    <= 1'b0;
    end else begin
      rd_pend <= mem_en;
      if (state == IDLE && start && num_words != 16'd0) begin
        mem_en     <= 1'b1;
        mem_addr   <= base_addr;
        issue_left <= num_words - 16'd1;
      end else if (state == RUN && issue_left != 16'd0 && credit_ok) begin
        mem_en     <= 1'b1;
        mem_addr   <= mem_addr + ADDR_WIDTH'(1);
        issue_left <= issue_left - 16'd1;
      end else begin
        mem_en <= 1'b0;
      end
    end
  end

  // Output serializer: holds one word and steps through its bytes on each handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_reg  <= '0;
      byte_idx  <= '0;
      word_last <= 1'b0;
      pix_valid <= 1'b0;
      out_left  <= '0;
    end else begin
      if (state == IDLE && start) out_left <= num_words;
      else if (load_word)         out_left <= out_left - 16'd1;

      if (load_word) begin
        word_reg  <= load_data;
        byte_idx  <= '0;
        word_last <= (out_left == 16'd1);
        pix_valid <= 1'b1;
      end else if (handshake) begin
        if (byte_idx == LAST_BYTE) pix_valid <= 1'b0;
        else                       byte_idx  <= byte_idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_word_reader.sv
// tb/tb_pixel_word_reader.sv - self-checking bench for pixel_word_reader
module tb_pixel_word_reader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] num_words;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_dr;
  logic [7:0]  pix;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_last;
  logic        busy;
  logic        done;

  pixel_word_reader #(.ADDR_WIDTH(16), .FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_dr    (mem_dr),
    .pix       (pix),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_last  (pix_last),
    .busy      (busy),
    .done      (done)
  );

  typedef struct packed {
    logic [7:0] p;
    logic       l;
    logic       f;
  } pix_t;

  typedef struct {
    logic [15:0] base;
    logic [15:0] num;
    int          mode;
    int          exp_first;
    int          exp_done;
  } vec_t;

  logic [31:0] mem [0:65535];
  pix_t        exp_pix[$];
  logic [15:0] exp_addr[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_count = 0;
  int done_count = 0;
  int first_cyc = -1;
  int done_cyc = -1;
  int issued = 0;
  int started = 0;
  logic busy_at_done = 1'b0;
  logic prev_hold = 1'b0;
  logic [7:0] prev_pix = '0;
  logic prev_last = 1'b0;
  logic [15:0] model_addr = '0;
  pix_t mon_e;
  logic [15:0] mon_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_en) mem_dr <= mem[mem_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h cycle=%0d", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_hold  = 1'b0;
      model_addr = '0;
      issued     = 0;
      started    = 0;
    end else begin
      if (prev_hold) begin
        chk("hold_pix", pix, prev_pix);
        chk("hold_valid", pix_valid, 1);
        chk("hold_last", pix_last, prev_last);
      end
      if (pix_valid && first_cyc < 0) first_cyc = cyc;
      if (pix_valid && exp_pix.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pixel got pix=%h with no pixel expected, cycle=%0d", pix, cyc);
      end else if (pix_valid && pix_ready) begin
        mon_e = exp_pix.pop_front();
        chk("pix_data", pix, mon_e.p);
        chk("pix_last", pix_last, mon_e.l);
        if (mon_e.f) started++;
        hs_count++;
      end
      if (mem_en) begin
        chk("mem_we", mem_we, 0);
        if (exp_addr.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_read got addr=%h with no read expected, cycle=%0d", mem_addr, cyc);
        end else begin
          mon_a = exp_addr.pop_front();
          chk("mem_addr", mem_addr, mon_a);
          model_addr = mon_a;
        end
        issued++;
        chk("buffer_bound", (issued - started) <= 3, 1);
      end else begin
        chk("mem_addr_hold", mem_addr, model_addr);
      end
      if (done) begin
        done_count++;
        done_cyc     = cyc;
        busy_at_done = busy;
      end
      prev_hold = pix_valid && !pix_ready;
      prev_pix  = pix;
      prev_last = pix_last;
    end
  end

  task automatic load_expect(input logic [15:0] base, input logic [15:0] num);
    logic [15:0] a;
    pix_t e;
    for (int w = 0; w < int'(num); w++) begin
      a = base + 16'(w);
      exp_addr.push_back(a);
      for (int b = 0; b < 4; b++) begin
        e.p = mem[a][8*b +: 8];
        e.l = (w == int'(num) - 1) && (b == 3);
        e.f = (b == 0);
        exp_pix.push_back(e);
      end
    end
  endtask

  task automatic next_ready(input int mode);
    case (mode)
      1:       pix_ready = ~pix_ready;
      2:       pix_ready = ($urandom_range(0, 3) != 0);
      default: pix_ready = 1'b1;
    endcase
  endtask

  task automatic run_xfer(input logic [15:0] base, input logic [15:0] num, input int mode,
                          input int exp_first, input int exp_done, input string name);
    int k;
    int n;
    int dc0;
    int hs0;
    load_expect(base, num);
    dc0 = done_count;
    hs0 = hs_count;
    first_cyc = -1;
    done_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = base;
    num_words = num;
    pix_ready = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
    k = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, "_busy_after_start"}, busy, (num != 16'd0));
    n = 0;
    while (done_count == dc0 && n < 2000) begin
      next_ready(mode);
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout no done after %0d cycles", name, n);
    end
    pix_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk({name, "_done_pulses"}, done_count - dc0, 1);
    chk({name, "_pixel_count"}, hs_count - hs0, 4 * int'(num));
    chk({name, "_pixels_left"}, exp_pix.size(), 0);
    chk({name, "_reads_left"}, exp_addr.size(), 0);
    chk({name, "_busy_at_done"}, busy_at_done, 0);
    if (exp_first >= 0) chk({name, "_first_valid_latency"}, first_cyc - k, exp_first);
    if (exp_done >= 0) chk({name, "_done_latency"}, done_cyc - k, exp_done);
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    int dc0;
    int hs0;
    logic [15:0] rb;

    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    num_words = '0;
    pix_ready = 1'b1;
    mem_dr = '0;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    mem[0] = 32'h44332211;
    mem[1] = 32'h88776655;

    vecs[0] = '{base: 16'h0000, num: 16'd2, mode: 0, exp_first: 3,  exp_done: 11};
    vecs[1] = '{base: 16'hFFFF, num: 16'd2, mode: 0, exp_first: 3,  exp_done: 11};
    vecs[2] = '{base: 16'h0000, num: 16'd0, mode: 0, exp_first: -1, exp_done: 1};
    vecs[3] = '{base: 16'h0100, num: 16'd4, mode: 1, exp_first: 3,  exp_done: -1};
    vecs[4] = '{base: 16'h1234, num: 16'd1, mode: 0, exp_first: 3,  exp_done: 7};
    vecs[5] = '{base: 16'h0200, num: 16'd3, mode: 0, exp_first: 3,  exp_done: 15};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_mem_en", mem_en, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_pix", pix, 0);
    chk("reset_pix_valid", pix_valid, 0);
    chk("reset_pix_last", pix_last, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_mem_we", mem_we, 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++)
      run_xfer(vecs[i].base, vecs[i].num, vecs[i].mode, vecs[i].exp_first, vecs[i].exp_done,
               $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      rb = (i % 3 == 0) ? 16'hFFFE : 16'($urandom);
      run_xfer(rb, 16'($urandom_range(1, 6)), 2, -1, -1, $sformatf("rand%0d", i));
    end

    // Reset in the middle of an 8-word transfer, then a fresh 1-word transfer.
    load_expect(16'h0300, 16'd8);
    dc0 = done_count;
    hs0 = hs_count;
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = 16'h0300;
    num_words = 16'd8;
    pix_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (hs_count - hs0 < 5 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_pixels_before_reset", hs_count - hs0, 5);
    reset = 1'b1;
    pix_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_pix.delete();
    exp_addr.delete();
    chk("abort_mem_en", mem_en, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_pix", pix, 0);
    chk("abort_pix_valid", pix_valid, 0);
    chk("abort_pix_last", pix_last, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    pix_ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("abort_no_done", done_count - dc0, 0);
    run_xfer(16'h0400, 16'd1, 0, 3, 7, "post_abort");

    // Start held high across a whole 1-word transfer: exactly one restart after IDLE.
    load_expect(16'h0500, 16'd1);
    load_expect(16'h0500, 16'd1);
    dc0 = done_count;
    hs0 = hs_count;
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = 16'h0500;
    num_words = 16'd1;
    pix_ready = 1'b1;
    n = 0;
    while (done_count == dc0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("held_first_done", done_count - dc0, 1);
    chk("held_idle_busy", busy, 0);
    chk("held_idle_done", done, 0);
    @(posedge clk); #1;
    chk("held_restart_busy", busy, 1);
    start = 1'b0;
    n = 0;
    while (done_count < dc0 + 2 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("held_done_pulses", done_count - dc0, 2);
    chk("held_pixel_count", hs_count - hs0, 8);
    chk("held_pixels_left", exp_pix.size(), 0);
    chk("held_reads_left", exp_addr.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_word_reader.md
PIXEL_WORD_READER -- requirements
Module: pixel_word_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, word-address width of memory port A.
REQ-002 Parameter FIFO_DEPTH, default 2, word buffer entries; minimum 2.
REQ-003 clk  in  1  single system clock; all logic rises on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  begin a transfer; sampled only in IDLE.
REQ-006 base_addr  in  ADDR_WIDTH  first word address; captured on accepted start.
REQ-007 num_words  in  16  words to read; captured on accepted start.
REQ-008 mem_en  out  1  memory port A enable.
REQ-009 mem_we  out  1  memory port A write enable; constant 0.
REQ-010 mem_addr  out  ADDR_WIDTH  memory port A word address.
REQ-011 mem_dr  in  32  memory read data, valid one cycle after mem_en.
REQ-012 pix  out  8  output pixel.
REQ-013 pix_valid  out  1  pix holds a valid pixel.
REQ-014 pix_ready  in  1  consumer accepts pix this cycle.
REQ-015 pix_last  out  1  marks final pixel; qualified by pix_valid.
REQ-016 busy  out  1  high from accepted start until done.
REQ-017 done  out  1  one-cycle completion pulse.

Function
REQ-018 The block SHALL implement FSM states IDLE, RUN, DONE: IDLE->RUN on start; RUN->DONE on handshake of the pix_last pixel; DONE->IDLE unconditionally after one cycle.
REQ-019 A start with num_words=0 SHALL go IDLE->DONE directly, without asserting mem_en or pix_valid.
REQ-020 start while busy=1 SHALL be ignored; start held high in DONE SHALL NOT start a new transfer until IDLE.
REQ-021 Reads SHALL be issued at addresses base_addr, base_addr+1, ... for num_words words, with the address wrapping modulo 2^ADDR_WIDTH.
REQ-022 A read SHALL be issued only when (buffered words + reads in flight) < FIFO_DEPTH, so no returned word is ever dropped.
REQ-023 Each 32-bit word SHALL be emitted as 4 pixels, in the order bits[7:0], [15:8], [23:16], [31:24].
REQ-024 Handshake: a pixel transfers when pix_valid and pix_ready are both 1; while pix_ready=0, pix, pix_valid, and pix_last SHALL remain stable.
REQ-025 pix_valid SHALL NOT depend combinationally on pix_ready.
REQ-026 With pix_ready held at 1, the first pix_valid SHALL be asserted exactly 3 cycles after the cycle start is sampled, and output SHALL sustain 1 pixel per cycle with no bubbles.
REQ-027 pix_last SHALL be 1 only on byte 3 of word num_words-1.
REQ-028 done SHALL pulse in the cycle after the last handshake; busy SHALL drop in that same cycle.
REQ-029 mem_addr SHALL hold its last value when mem_en=0.

Reset
REQ-030 On reset, the FSM SHALL go to IDLE, the FIFO SHALL be emptied, in-flight read data SHALL be discarded, and mem_en, pix_valid, pix_last, busy, done, mem_addr, and pix SHALL all be 0.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer without a done pulse; the next start SHALL behave as a fresh transfer.

Structure
REQ-032 The FSM state enum and the PIXELS_PER_WORD=4 constant SHALL be placed in the shared package edge_pkg.
REQ-033 The word buffer SHALL be a sub-module word_fifo (parameters WIDTH and DEPTH; synchronous reset; full and empty flags; push and pop in the same cycle when full is allowed).

Verification
REQ-034 base=0x0000, num=2, mem[0]=0x44332211, mem[1]=0x88776655, ready=1 -> pixels 11..88 on consecutive cycles starting at start+3; pix_last on 0x88; done one cycle later.
REQ-035 num=0 -> done pulses at start+1; mem_en and pix_valid never asserted.
REQ-036 base=0xFFFF, num=2 -> mem_addr sequence 0xFFFF, 0x0000.
REQ-037 num=4 with pix_ready toggling 1/0 every cycle -> 16 pixels in order; outputs stable while ready=0; FIFO never exceeds 2; no words lost.
REQ-038 reset pulsed after 5 pixels of a num=8 transfer -> all outputs 0 on the next cycle, no done; a following start with num=1 yields exactly 4 correct pixels.
REQ-039 start held high during the entire num=1 transfer -> only one transfer occurs, then a second transfer starts after returning to IDLE.
